seg_pattern_reader: RTL and testbench

- Inverse of the team's binary-to-7-segment decoder.
- Samples active-low 7-segment patterns (e.g. tapped from a display bus or a scanned panel) and debounces them by requiring N identical consecutive samples.
- Converts each stable pattern back to a binary digit code and delivers it through a one-entry valid/ready output buffer, with invalid-glyph flagging and error statistics.
- Used for display loopback self-check and for reading external 7-segment sources.

---
 rtl/seg_pattern_reader_if.sv | 25 ++
 rtl/seg_pattern_reader.sv | 137 +++++++++++++
 tb/tb_seg_pattern_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pattern_reader_if.sv
// Sample, output-buffer and error-statistics signals of seg_pattern_reader.
// The master modport is the reader itself; slave is the source/consumer side.
interface seg_pattern_reader_if #(
  parameter int ERR_CNT_W = 8
);
  logic [6:0]           seg_in;
  logic                 seg_valid;
  logic [3:0]           code_out;
  logic                 code_invalid;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 clr_err;

  modport master (
    input  seg_in, seg_valid, out_ready, clr_err,
    output code_out, code_invalid, out_valid, overflow, err_count
  );

  modport slave (
    output seg_in, seg_valid, out_ready, clr_err,
    input  code_out, code_invalid, out_valid, overflow, err_count
  );
endinterface

// File: rtl/seg_pattern_reader.sv
// Debounced active-low 7-segment pattern reader with a one-entry output buffer.
// Define SEG_READER_HEX_EN to accept the hex glyphs 8..F as well as 0..7.
module seg_pattern_reader #(
  parameter int STABLE_CNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_pattern_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [4:0] STABLE = 5'(STABLE_CNT);

  state_t               state_p0;
  logic [6:0]           cand_p0;
  logic [3:0]           cnt_p0;
  logic [3:0]           code_p1;
  logic                 inv_p1;
  logic                 vld_p1;
  logic                 ovf_p1;
  logic [ERR_CNT_W-1:0] err_p1;

  logic                 match;
  logic                 emit;
  logic                 slot_free;
  logic [4:0]           dec;

  // Returns {invalid, code}; unknown glyphs decode to code 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
`ifdef SEG_READER_HEX_EN
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage 0: debounce decision on the incoming sample
  always_comb begin
    match = (bus.seg_in == cand_p0);
    emit  = 1'b0;
    if (bus.seg_valid) begin
      case (state_p0)
        IDLE:    emit = (STABLE == 5'd1);
        TRACK:   emit = match ? (({1'b0, cnt_p0} + 5'd1) == STABLE) : (STABLE == 5'd1);
        LOCKED:  emit = !match && (STABLE == 5'd1);
        default: emit = 1'b0;
      endcase
    end
    dec       = decode(bus.seg_in);
    slot_free = !vld_p1 || bus.out_ready;
  end

  // Stage 1: tracker state, output buffer and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cand_p0  <= '0;
      cnt_p0   <= '0;
      code_p1  <= '0;
      inv_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      err_p1   <= '0;
    end else begin
      if (bus.seg_valid) begin
        case (state_p0)
          IDLE: begin
            cand_p0  <= bus.seg_in;
            cnt_p0   <= 4'd1;
            state_p0 <= emit ? LOCKED : TRACK;
          end
          TRACK: begin
            cand_p0  <= bus.seg_in;
            cnt_p0   <= match ? cnt_p0 + 4'd1 : 4'd1;
            state_p0 <= emit ? LOCKED : TRACK;
          end
          LOCKED: begin
            if (!match) begin
              cand_p0  <= bus.seg_in;
              cnt_p0   <= 4'd1;
              state_p0 <= emit ? LOCKED : TRACK;
            end
          end
          default: state_p0 <= IDLE;
        endcase
      end

      if (emit && slot_free) begin
        code_p1 <= dec[3:0];
        inv_p1  <= dec[4];
        vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1  <= 1'b0;
      end

      // A clear beats a same-cycle increment or overflow.
      if (bus.clr_err) begin
        err_p1 <= '0;
        ovf_p1 <= 1'b0;
      end else begin
        if (emit && dec[4])     err_p1 <= sat_inc(err_p1);
        if (emit && !slot_free) ovf_p1 <= 1'b1;
      end
    end
  end

  assign bus.code_out     = code_p1;
  assign bus.code_invalid = inv_p1;
  assign bus.out_valid    = vld_p1;
  assign bus.overflow     = ovf_p1;
  assign bus.err_count    = err_p1;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Bench for seg_pattern_reader: constant vector table, directed corner sequences
// and randomized traffic against a run-length reference model.
module tb_seg_pattern_reader;

  localparam int STABLE_CNT = 3;
  localparam int ERR_CNT_W  = 8;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;
`ifdef SEG_READER_HEX_EN
  localparam int NDIG = 16;
`else
  localparam int NDIG = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_pattern_reader_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  seg_pattern_reader #(.STABLE_CNT(STABLE_CNT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: run length of identical valid samples plus a one-slot buffer.
  logic [6:0] run_pat;
  int         run_len;
  logic       m_vld, m_inv, m_ovf;
  logic [3:0] m_code;
  int         m_err;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < NDIG; i++)
      if (glyph[i] == s) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  task automatic model_update(input logic [6:0] s, input logic v, input logic rdy,
                              input logic clr, input logic rn);
    logic       emit;
    logic [4:0] d;
    logic       ovf_set;
    if (!rn) begin
      run_len = 0; m_vld = 0; m_code = 0; m_inv = 0; m_ovf = 0; m_err = 0;
      return;
    end
    emit = 0; ovf_set = 0;
    if (v) begin
      if (run_len > 0 && s == run_pat) run_len++;
      else begin run_pat = s; run_len = 1; end
      emit = (run_len == STABLE_CNT);
    end
    d = ref_decode(s);
    if (emit) begin
      if (!m_vld || rdy) begin m_vld = 1; m_code = d[3:0]; m_inv = d[4]; end
      else ovf_set = 1;
    end else if (m_vld && rdy) m_vld = 0;
    if (clr) begin m_err = 0; m_ovf = 0; end
    else begin
      if (emit && d[4] && m_err < ERR_MAX) m_err++;
      if (ovf_set) m_ovf = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    else pass_cnt++;
  endtask

  task automatic check_model();
    chk("out_valid",    32'(bus.out_valid),    32'(m_vld));
    chk("code_out",     32'(bus.code_out),     32'(m_code));
    chk("code_invalid", 32'(bus.code_invalid), 32'(m_inv));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("err_count",    32'(bus.err_count),    32'(m_err));
  endtask

  // Drive one cycle's inputs, advance one edge, then compare against the model.
  task automatic step(input logic [6:0] s, input logic v, input logic rdy,
                      input logic clr, input logic rn);
    bus.seg_in = s; bus.seg_valid = v; bus.out_ready = rdy; bus.clr_err = clr; rst_n = rn;
    @(posedge clk);
    model_update(s, v, rdy, clr, rn);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [6:0] seg;
    logic       v;
    logic       rdy;
    logic       rn;
    logic       ev;
    logic [3:0] ecode;
    logic       einv;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic [6:0] s, input logic v, input logic rdy, input logic rn,
                      input logic ev, input logic [3:0] ec, input logic ei);
    vec_t x;
    x.seg = s; x.v = v; x.rdy = rdy; x.rn = rn; x.ev = ev; x.ecode = ec; x.einv = ei;
    tbl.push_back(x);
  endtask

  int         pick;
  logic [6:0] cur;
  logic [4:0] exp46;

  initial begin
    bus.seg_in = '0; bus.seg_valid = 0; bus.out_ready = 0; bus.clr_err = 0; rst_n = 0;
    run_pat = '0; run_len = 0;
    m_vld = 0; m_code = 0; m_inv = 0; m_ovf = 0; m_err = 0;

    // reset held with valid samples present
    addv(7'h24, 1, 1, 0, 0, 4'd0, 0);
    addv(7'h24, 1, 1, 0, 0, 4'd0, 0);
    // 0x24 x3 -> one entry of 2, drained next cycle
    addv(7'h24, 1, 1, 1, 0, 4'd0, 0);
    addv(7'h24, 1, 1, 1, 0, 4'd0, 0);
    addv(7'h24, 1, 1, 1, 1, 4'd2, 0);
    addv(7'h00, 0, 1, 1, 0, 4'd2, 0);
    // debounce: broken run of 0x30, then 0x19 x3 -> 4
    addv(7'h30, 1, 1, 1, 0, 4'd2, 0);
    addv(7'h30, 1, 1, 1, 0, 4'd2, 0);
    addv(7'h19, 1, 1, 1, 0, 4'd2, 0);
    addv(7'h19, 1, 1, 1, 0, 4'd2, 0);
    addv(7'h19, 1, 1, 1, 1, 4'd4, 0);
    for (int i = 0; i < 5; i++) addv(7'h19, 1, 1, 1, 0, 4'd4, 0);
    // seg_valid gaps do not break a run
    addv(7'h12, 1, 1, 1, 0, 4'd4, 0);
    for (int i = 0; i < 4; i++) addv(7'h55, 0, 1, 1, 0, 4'd4, 0);
    addv(7'h12, 1, 1, 1, 0, 4'd4, 0);
    addv(7'h33, 0, 1, 1, 0, 4'd4, 0);
    addv(7'h12, 1, 1, 1, 1, 4'd5, 0);
    addv(7'h00, 0, 1, 1, 0, 4'd5, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].seg, tbl[i].v, tbl[i].rdy, 1'b0, tbl[i].rn);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_code", i),  32'(bus.code_out),  32'(tbl[i].ecode));
      chk($sformatf("vec%0d_inv", i),   32'(bus.code_invalid), 32'(tbl[i].einv));
    end

    // backpressure: 1 held, 7 dropped, overflow set, single transfer
    repeat (3) step(7'h79, 1, 0, 0, 1);
    repeat (3) step(7'h78, 1, 0, 0, 1);
    chk("bp_code_held", 32'(bus.code_out), 32'd1);
    chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
    chk("bp_overflow", 32'(bus.overflow), 32'd1);
    step(7'h00, 0, 1, 0, 1);
    chk("bp_transfer_done", 32'(bus.out_valid), 32'd0);
    chk("bp_transfer_code", 32'(bus.code_out), 32'd1);
    step(7'h00, 0, 1, 0, 1);
    chk("bp_single_transfer", 32'(bus.out_valid), 32'd0);
    step(7'h00, 0, 1, 1, 1);
    chk("clr_overflow", 32'(bus.overflow), 32'd0);

    // 'E' glyph: invalid by default, 14 with the hex table
    repeat (3) step(7'h06, 1, 1, 0, 1);
`ifdef SEG_READER_HEX_EN
    chk("e_code", 32'(bus.code_out), 32'd14);
    chk("e_invalid", 32'(bus.code_invalid), 32'd0);
    chk("e_err", 32'(bus.err_count), 32'd0);
    exp46 = 5'h0C;
`else
    chk("e_code", 32'(bus.code_out), 32'd0);
    chk("e_invalid", 32'(bus.code_invalid), 32'd1);
    chk("e_err", 32'(bus.err_count), 32'd1);
    exp46 = 5'h10;
`endif
    repeat (3) step(7'h46, 1, 1, 0, 1);
    chk("c_code", 32'(bus.code_out), 32'(exp46[3:0]));
    chk("c_invalid", 32'(bus.code_invalid), 32'(exp46[4]));

    // saturation: 260 alternating invalid runs
    for (int r = 0; r < 260; r++) begin
      cur = (r % 2 == 0) ? 7'h7F : 7'h7E;
      repeat (3) step(cur, 1, 1, 0, 1);
    end
    chk("err_saturated", 32'(bus.err_count), 32'(ERR_MAX));
    // clear coinciding with an invalid emission
    step(7'h7F, 1, 1, 0, 1);
    step(7'h7F, 1, 1, 0, 1);
    step(7'h7F, 1, 1, 1, 1);
    chk("clr_beats_inc", 32'(bus.err_count), 32'd0);
    chk("clr_emit_inv", 32'(bus.code_invalid), 32'd1);

    // reset in the middle of a pending entry
    repeat (3) step(7'h02, 1, 0, 0, 1);
    step(7'h02, 1, 1, 0, 0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_code", 32'(bus.code_out), 32'd0);

    // randomized traffic, mostly long runs so emissions are frequent
    cur = 7'h40;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 30) begin
        pick = $urandom_range(18);
        if (pick < 16) cur = glyph[pick];
        else if (pick == 16) cur = 7'h7F;
        else if (pick == 17) cur = 7'h55;
        else cur = 7'(($urandom));
      end
      step(cur, ($urandom_range(99) < 80), ($urandom_range(99) < 60),
           ($urandom_range(99) < 3), ($urandom_range(199) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
